nor_sweep_ctrl: RTL and testbench
=================================

Name: nor_sweep_ctrl

Overview:
Self-test sequencer for the 3-input NOR cell nor_1_bit. On a start request it drives all 8 input combinations onto the cell and waits a programmable settle time per vector. It then samples the cell output and compares it against the expected truth table, reporting a result vector, an error count and the first failing index. It sits beside the gate in lab builds and replaces hand-written stimulus for board-level checking.

Parameters:
SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..15.
EXPECTED, 8'h01, expected x for index i = {a,b,c} at bit i; NOR truth table.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  level; sampled only in IDLE; begins a sweep.
abort  in  1  level; cancels a sweep in progress.
dut_x  in  1  output of the cell under test.
drv_a  out  1  registered drive to cell input a (index bit 2).
drv_b  out  1  registered drive to cell input b (index bit 1).
drv_c  out  1  registered drive to cell input c (index bit 0).
busy  out  1  high while sweeping.
done  out  1  one-cycle pulse when a sweep completes.
pass  out  1  high when the last completed sweep had zero errors; held until the next start.
result  out  8  sampled dut_x per index.
err_count  out  4  number of mismatching indices, 0..8.
first_fail  out  3  lowest mismatching index.
fail_valid  out  1  first_fail is meaningful.

Behaviour:
- Reset (asynchronous, rst=1):
  - state IDLE, idx=0, settle counter=0.
  - All outputs 0.
- States: IDLE, SETTLE, SAMPLE, FINISH. Encoding is binary; IDLE=0.
- IDLE:
  - On an edge with start=1 and abort=0: idx<=0, {drv_a,drv_b,drv_c}<=3'b000, cnt<=SETTLE_CYCLES-1.
  - On the same edge: clear result, err_count, first_fail, fail_valid and pass; busy<=1; go to SETTLE.
  - Otherwise drv outputs hold 0.
- SETTLE:
  - While cnt!=0, cnt<=cnt-1.
  - When cnt==0, go to SAMPLE.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - result[idx]<=dut_x.
  - If dut_x!=EXPECTED[idx]: err_count<=err_count+1. If fail_valid=0, also set first_fail<=idx and fail_valid<=1.
  - If idx==7: go to FINISH.
  - Else: idx<=idx+1, drv<=idx+1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- FINISH (one cycle):
  - done=1, busy<=0, pass<=(err_count==0), drv<=0, go to IDLE.
  - pass uses the final err_count, including the index-7 update.
- Timing:
  - Vector n is sampled at edge (n+1)*(SETTLE_CYCLES+1) after the start-sampling edge.
  - done is high in the cycle after edge 8*(SETTLE_CYCLES+1).
  - With the default of 2, done is high after edge 24.
- start while busy: ignored. A start held high across FINISH begins a new sweep from IDLE on the following edge.
- abort:
  - In SETTLE or SAMPLE: next edge goes to IDLE, drv<=0, busy<=0, no done pulse, pass stays 0.
  - Partial result, err_count and first_fail are retained. The sample in an aborted SAMPLE cycle is not recorded.
  - abort takes priority over start.
- Reset mid-sweep: immediate return to the reset values above; no done.
- err_count is 4 bits, so a count of 8 never wraps.
- dut_x is treated as synchronous to clk because the cell is combinational on the registered drv outputs; no synchroniser.

Decomposition:
- Shared include nor_defs.vh holds:
  - State encodings ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_FINISH.
  - NOR3_TRUTH = 8'h01.
  - IDX_W = 3.
- One natural sub-module, settle_timer: loadable down-counter with a zero flag, width 4.
- nor_1_bit is not instantiated inside; the bench and top level connect drv_* and dut_x to it.

Test Plan:
1. Good cell: nor_1_bit connected, start pulsed 1 cycle, SETTLE_CYCLES=2 -> done after edge 24; result=8'h01, err_count=0, pass=1, fail_valid=0; drv sequence 000..111, each held 3 cycles.
2. Stuck-at-0 model (dut_x=0) -> result=8'h00, err_count=1, first_fail=0, fail_valid=1, pass=0.
3. Stuck-at-1 model -> result=8'hFF, err_count=7, first_fail=1, pass=0. Separately, a model ignoring c (x=~(a|b)) -> result=8'h03, err_count=1, first_fail=1.
4. abort asserted during vector 4 SETTLE -> busy falls next edge, no done, drv=000, result[3:0]=4'b0001 retained, pass=0.
5. rst pulsed mid-sweep, asynchronously between edges -> all outputs 0 immediately. start re-pulsed after rst releases -> full sweep completes with pass=1.
6. start held high continuously -> back-to-back sweeps. Each done is one cycle; the next busy rise is 2 edges after done; start pulses while busy have no effect.

Source files
------------

// File: rtl/nor_sweep_ctrl_pkg.sv
// Shared types and constants for the nor_1_bit self-test sequencer.
// Holds the state encoding, the NOR3 truth table and index widths.
package nor_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [7:0] NOR3_TRUTH = 8'h01;
  localparam int         IDX_W      = 3;
  localparam int         CNT_W      = 4;

endpackage

// File: rtl/nor_sweep_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag.
// Paces how long each vector is held on the cell before sampling.
module nor_sweep_ctrl_settle_timer
  import nor_sweep_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nor_sweep_ctrl.sv
// Self-test sequencer for a 3-input NOR cell: sweeps all 8 inputs,
// samples the cell after a settle time and tallies mismatches.
module nor_sweep_ctrl
  import nor_sweep_ctrl_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED      = NOR3_TRUTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_x,
  output logic             drv_a,
  output logic             drv_b,
  output logic             drv_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       result,
  output logic [3:0]       err_count,
  output logic [IDX_W-1:0] first_fail,
  output logic             fail_valid
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] drv_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [7:0]       result_q;
  logic [3:0]       err_q;
  logic [IDX_W-1:0] ff_q;
  logic             fv_q;

  logic tmr_load_d;
  logic tmr_dec_d;
  logic tmr_zero;
  logic go_d;
  logic last_d;

  // Timer control: load on sweep start and on each advance to a new vector.
  always_comb begin
    go_d       = (state_q == ST_IDLE) && start && !abort;
    last_d     = (idx_q == IDX_W'(7));
    tmr_load_d = go_d ||
                 ((state_q == ST_SAMPLE) && !abort && !last_d);
    tmr_dec_d  = (state_q == ST_SETTLE) && !tmr_zero;
  end

  nor_sweep_ctrl_settle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_d),
    .load_val_i (LOAD_VAL),
    .dec_i      (tmr_dec_d),
    .zero_o     (tmr_zero)
  );

  // Sweep FSM with registered drive, status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      drv_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          drv_q <= '0;
          if (go_d) begin
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            fv_q     <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            drv_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmr_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            drv_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            result_q[idx_q] <= dut_x;
            if (dut_x != EXPECTED[idx_q]) begin
              err_q <= err_q + 4'd1;
              if (!fv_q) begin
                ff_q <= idx_q;
                fv_q <= 1'b1;
              end
            end
            if (last_d) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              drv_q   <= idx_q + IDX_W'(1);
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          pass_q  <= (err_q == 4'd0);
          drv_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign drv_a      = drv_q[2];
  assign drv_b      = drv_q[1];
  assign drv_c      = drv_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign result     = result_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_nor_sweep_ctrl.sv
// Self-checking bench for nor_sweep_ctrl with a swappable cell model.
// Table vectors, hand sequences and random truth tables vs a model.
module tb_nor_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       dut_x;
  logic       drv_a, drv_b, drv_c;
  logic       busy, done, pass;
  logic [7:0] result;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic       fail_valid;

  logic       use_nor;
  logic [7:0] cell_tbl;
  logic [2:0] sel;

  int checks   = 0;
  int failures = 0;

  nor_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECTED(8'h01)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dut_x      (dut_x),
    .drv_a      (drv_a),
    .drv_b      (drv_b),
    .drv_c      (drv_c),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .result     (result),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_valid (fail_valid)
  );

  always #5 clk = ~clk;

  assign sel   = {drv_a, drv_b, drv_c};
  assign dut_x = use_nor ? ~(drv_a | drv_b | drv_c) : cell_tbl[sel];

  typedef struct {
    string      name;
    logic       nor_cell;
    logic [7:0] tbl;
    logic [7:0] exp_res;
    logic [3:0] exp_err;
    logic [2:0] exp_ff;
    logic       exp_fv;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Pulse start, wait for done, then step past FINISH.
  // lat = edge count after the start edge at which done is seen.
  task automatic run_sweep(input logic glitch, input logic trace,
                           output int lat);
    int bad_drv;
    int bad_busy;
    logic [2:0] exp_drv;
    bad_drv  = 0;
    bad_busy = 0;
    lat      = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      start = glitch && (k == 6);
      exp_drv = (k >= 24) ? 3'd7 : 3'(k / 3);
      if (sel !== exp_drv) bad_drv++;
      if (busy !== 1'b1) bad_busy++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("done_latency", lat, 24);
    if (trace) begin
      chk("drv_sequence", bad_drv, 0);
      chk("busy_held", bad_busy, 0);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("drv_after", sel, 3'd0);
  endtask

  task automatic chk_status(input string nm, input logic [7:0] r,
                            input logic [3:0] e, input logic [2:0] f,
                            input logic v, input logic p);
    chk({nm, "_result"}, result, r);
    chk({nm, "_err"}, err_count, e);
    if (v) chk({nm, "_first"}, first_fail, f);
    chk({nm, "_fvalid"}, fail_valid, v);
    chk({nm, "_pass"}, pass, p);
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0] m_res;
    logic [3:0] m_err;
    logic [2:0] m_ff;
    logic       m_fv;

    vecs[0] = '{"good",   1'b1, 8'h00, 8'h01, 4'd0, 3'd0, 1'b0, 1'b1};
    vecs[1] = '{"stuck0", 1'b0, 8'h00, 8'h00, 4'd1, 3'd0, 1'b1, 1'b0};
    vecs[2] = '{"stuck1", 1'b0, 8'hFF, 8'hFF, 4'd7, 3'd1, 1'b1, 1'b0};
    vecs[3] = '{"ign_c",  1'b0, 8'h03, 8'h03, 4'd1, 3'd1, 1'b1, 1'b0};
    vecs[4] = '{"invert", 1'b0, 8'hFE, 8'hFE, 4'd8, 3'd0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    use_nor = 1'b1; cell_tbl = 8'h00;
    #1;
    chk("reset_outputs",
        {sel, busy, done, pass, result, err_count, first_fail, fail_valid},
        '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      use_nor  = vecs[i].nor_cell;
      cell_tbl = vecs[i].tbl;
      run_sweep(1'b0, i == 0, lat);
      chk_status(vecs[i].name, vecs[i].exp_res, vecs[i].exp_err,
                 vecs[i].exp_ff, vecs[i].exp_fv, vecs[i].exp_pass);
    end

    // Abort during the SETTLE of vector 4.
    use_nor = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_drv", sel, 3'd0);
    chk("abort_result", result, 8'h01);
    chk("abort_pass", pass, 1'b0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Asynchronous reset between edges mid-sweep.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midreset_outputs",
        {sel, busy, done, pass, result, err_count, first_fail, fail_valid},
        '0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, 1'b0, lat);
    chk_status("after_reset", 8'h01, 4'd0, 3'd0, 1'b0, 1'b1);

    // Start held high: back-to-back sweeps.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1 if (done) begin lat = k; break; end
    end
    chk("b2b_first_done", lat, 24);
    @(posedge clk);
    #1;
    chk("b2b_gap_done", done, 1'b0);
    chk("b2b_gap_busy", busy, 1'b0);
    chk("b2b_pass", pass, 1'b1);
    @(posedge clk);
    #1 chk("b2b_busy_rise", busy, 1'b1);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1 if (done) begin lat = k; break; end
    end
    chk("b2b_second_done", lat, 24);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("b2b_idle", busy, 1'b0);

    // Random cell truth tables against a direct reference model.
    use_nor = 1'b0;
    for (int n = 0; n < 24; n++) begin
      cell_tbl = 8'($urandom);
      m_res = cell_tbl;
      m_err = 4'd0;
      m_ff  = 3'd0;
      m_fv  = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (cell_tbl[i] != ((i == 0) ? 1'b1 : 1'b0)) begin
          m_err++;
          m_ff = 3'(i);
          m_fv = 1'b1;
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(1'($urandom_range(0, 1)), 1'b0, lat);
      chk_status("rand", m_res, m_err, m_ff, m_fv, m_err == 4'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
